state_log_shifter: RTL and testbench

- Readout end of the 1-bit debug state loggers.
- Snapshots {prev, current} of NUM_CH logger channels on request and serialises them onto a slow 3-wire shift link (clock/data/frame) toward the BMC/debug header.
- Pulses a clear back to the loggers at snapshot time, so each readout reports only transitions since the previous readout.
- Bit rate is set by an external tick (iShiftEn) from the shared prescaler.

---
 rtl/state_log_shifter_pkg.sv | 20 ++
 rtl/state_log_shifter.sv | 134 +++++++++++++
 tb/tb_state_log_shifter.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/state_log_shifter_pkg.sv
// rtl/state_log_shifter_pkg.sv - shared types and constants for the debug state logger readout
package state_log_shifter_pkg;

    // Readout sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } shifter_state_e;

    // Sync byte that opens every frame, sent MSB-first
    localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

    // Frame length in bits: header byte, {curr, prev} per channel, one parity bit
    function automatic int frame_bits(input int num_ch);
        return 2 * num_ch + 9;
    endfunction

endpackage

// File: rtl/state_log_shifter.sv
// rtl/state_log_shifter.sv - snapshots logger {curr, prev} pairs and serialises them on a clock/data/frame link
module state_log_shifter
    import state_log_shifter_pkg::*;
#(
    parameter int         NUM_CH         = 16,
    parameter logic [7:0] HEADER         = DEFAULT_HEADER,
    parameter bit         CLR_AFTER_READ = 1'b1
) (
    input  logic              iClk,
    input  logic              iRst_n,
    input  logic              iStart,
    input  logic              iAbort,
    input  logic              iShiftEn,
    input  logic [NUM_CH-1:0] iPrevSt,
    input  logic [NUM_CH-1:0] iCurrSt,
    output logic              oClear,
    output logic              oSclk,
    output logic              oSdo,
    output logic              oFrame,
    output logic              oBusy,
    output logic              oDone
);

    localparam int NBITS  = frame_bits(NUM_CH);
    localparam int DATA_W = 2 * NUM_CH;
    localparam int IDX_W  = $clog2(NBITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBITS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    shifter_state_e   state_q, state_d;
    logic             sclk_q, sclk_d;
    logic             phase_q, phase_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [NBITS-1:0] sr_q, sr_d;

    logic [DATA_W-1:0] data_vec;
    logic [NBITS-1:0]  load_vec;

    // Interleave channels so channel 0 current state leaves first, followed by its prev state
    always_comb begin
        data_vec = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            data_vec[DATA_W-1-2*k] = iCurrSt[k];
            data_vec[DATA_W-2-2*k] = iPrevSt[k];
        end
    end

    // Whole frame pre-built so SHIFT only has to shift left; parity covers data only
    assign load_vec = {HEADER, data_vec, ^data_vec};

    // State, serial clock phase, bit index and shift register
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q <= ST_IDLE;
            sclk_q  <= 1'b0;
            phase_q <= 1'b0;
            idx_q   <= '0;
            sr_q    <= '0;
        end else begin
            state_q <= state_d;
            sclk_q  <= sclk_d;
            phase_q <= phase_d;
            idx_q   <= idx_d;
            sr_q    <= sr_d;
        end
    end

    // Next-state logic; abort takes priority over a coincident bit tick
    always_comb begin
        state_d = state_q;
        sclk_d  = sclk_q;
        phase_d = phase_q;
        idx_d   = idx_q;
        sr_d    = sr_q;
        unique case (state_q)
            ST_IDLE: begin
                sclk_d  = 1'b0;
                phase_d = 1'b0;
                if (iStart) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (iAbort) begin
                    state_d = ST_IDLE;
                end else begin
                    // Loggers clear on this same edge, so this captures pre-clear values
                    sr_d    = load_vec;
                    idx_d   = '0;
                    phase_d = 1'b0;
                    sclk_d  = 1'b0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (iAbort) begin
                    sclk_d  = 1'b0;
                    phase_d = 1'b0;
                    state_d = ST_IDLE;
                end else if (iShiftEn) begin
                    if (!phase_q) begin
                        sclk_d  = 1'b1;
                        phase_d = 1'b1;
                    end else begin
                        sclk_d  = 1'b0;
                        phase_d = 1'b0;
                        if (idx_q == LAST_IDX) begin
                            state_d = ST_DONE;
                        end else begin
                            idx_d = idx_q + IDX_ONE;
                            sr_d  = {sr_q[NBITS-2:0], 1'b0};
                        end
                    end
                end
            end
            ST_DONE: begin
                sclk_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decoded from registers only, so an async reset drops them at once
    assign oFrame = (state_q == ST_SHIFT);
    assign oSclk  = sclk_q & (state_q == ST_SHIFT);
    assign oSdo   = sr_q[NBITS-1] & (state_q == ST_SHIFT);
    assign oBusy  = (state_q != ST_IDLE);
    assign oDone  = (state_q == ST_DONE);
    assign oClear = (state_q == ST_LOAD) & CLR_AFTER_READ;

endmodule

// File: tb/tb_state_log_shifter.sv
// tb/tb_state_log_shifter.sv - scoreboard bench for state_log_shifter with NUM_CH=4
module tb_state_log_shifter;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort_r;
    logic       shift_en;
    logic [3:0] prev_st;
    logic [3:0] curr_st;
    logic       clr;
    logic       sclk;
    logic       sdo;
    logic       frame;
    logic       busy;
    logic       done;

    int   checks;
    int   failures;
    logic exp_q[$];

    state_log_shifter #(
        .NUM_CH        (4),
        .HEADER        (8'hA5),
        .CLR_AFTER_READ(1'b1)
    ) dut (
        .iClk    (clk),
        .iRst_n  (rst_n),
        .iStart  (start),
        .iAbort  (abort_r),
        .iShiftEn(shift_en),
        .iPrevSt (prev_st),
        .iCurrSt (curr_st),
        .oClear  (clr),
        .oSclk   (sclk),
        .oSdo    (sdo),
        .oFrame  (frame),
        .oBusy   (busy),
        .oDone   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic push_bits(input logic [7:0] v, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            logic b;
            b = v[i];
            exp_q.push_back(b);
        end
    endtask

    task automatic push_frame(input logic [7:0] data, input logic par);
        push_bits(8'hA5, 8);
        push_bits(data, 8);
        exp_q.push_back(par);
    endtask

    // Monitor: sample oSdo on every oSclk rise and compare with the scoreboard
    initial begin
        logic prev_sclk;
        logic e;
        prev_sclk = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_sclk = 1'b0;
            end else begin
                if (sclk && !prev_sclk) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_bit actual=%0d expected=none", sdo);
                    end else begin
                        e = exp_q.pop_front();
                        check("serial_bit", int'(sdo), int'(e));
                    end
                end
                prev_sclk = sclk;
            end
        end
    end

    task automatic clk_step(input bit scr);
        @(posedge clk);
        #1;
        if (scr) begin
            curr_st = 4'($urandom);
            prev_st = 4'($urandom);
        end
    endtask

    task automatic tick(input bit scr, input bit with_abort, input bit with_start);
        repeat (3) clk_step(scr);
        shift_en = 1'b1;
        abort_r  = with_abort;
        start    = with_start;
        clk_step(scr);
        shift_en = 1'b0;
        abort_r  = 1'b0;
        start    = 1'b0;
    endtask

    // Start pulse, LOAD cycle and entry into SHIFT
    task automatic begin_frame(input logic [3:0] curr, input logic [3:0] prev);
        curr_st = curr;
        prev_st = prev;
        start   = 1'b1;
        clk_step(1'b0);
        start = 1'b0;
        check("clear_in_load", int'(clr), 1);
        check("busy_in_load", int'(busy), 1);
        clk_step(1'b0);
        check("clear_one_cycle", int'(clr), 0);
        check("frame_in_shift", int'(frame), 1);
        check("sclk_starts_low", int'(sclk), 0);
    endtask

    task automatic run_frame(input logic [3:0] curr, input logic [3:0] prev,
                             input logic [7:0] data, input logic par,
                             input bit scr, input bit spam);
        int  ticks;
        bit  done_seen;
        push_frame(data, par);
        begin_frame(curr, prev);
        ticks     = 0;
        done_seen = 1'b0;
        while (!done_seen && ticks < 40) begin
            tick(scr, 1'b0, spam && (ticks == 10));
            ticks++;
            if (done) done_seen = 1'b1;
        end
        check("tick_count", ticks, 34);
        check("done_pulse", int'(done_seen), 1);
        check("frame_low_in_done", int'(frame), 0);
        check("sclk_low_in_done", int'(sclk), 0);
        start = spam;
        clk_step(1'b0);
        start = 1'b0;
        check("done_one_cycle", int'(done), 0);
        check("busy_after_done", int'(busy), 0);
        clk_step(1'b0);
        check("no_second_frame", int'(busy), 0);
        check("bits_consumed", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        abort_r  = 1'b0;
        shift_en = 1'b0;
        curr_st  = '0;
        prev_st  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_frame", int'(frame), 0);
        check("rst_sclk", int'(sclk), 0);
        check("rst_sdo", int'(sdo), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_clear", int'(clr), 0);
        rst_n = 1'b1;
        clk_step(1'b0);

        // curr=1010 prev=0110 -> pairs (0,0)(1,1)(0,1)(1,0), parity 0
        run_frame(4'b1010, 4'b0110, 8'b0011_0110, 1'b0, 1'b0, 1'b0);
        // curr=0001 prev=0000 -> 1,0,0,0,0,0,0,0, parity 1
        run_frame(4'b0001, 4'b0000, 8'b1000_0000, 1'b1, 1'b0, 1'b0);
        // curr=1100 prev=0101 -> (0,1)(0,0)(1,1)(1,0), parity 0; inputs churn during SHIFT
        run_frame(4'b1100, 4'b0101, 8'b0100_1110, 1'b0, 1'b1, 1'b0);
        // same vector with iStart pulses during SHIFT and DONE
        run_frame(4'b1010, 4'b0110, 8'b0011_0110, 1'b0, 1'b0, 1'b1);

        // Abort coinciding with the 6th tick: header bits 1,0,1 are seen first
        push_bits(8'hA5, 3);
        begin_frame(4'b1111, 4'b1111);
        repeat (5) tick(1'b0, 1'b0, 1'b0);
        check("sclk_high_before_abort", int'(sclk), 1);
        tick(1'b0, 1'b1, 1'b0);
        check("abort_frame", int'(frame), 0);
        check("abort_sclk", int'(sclk), 0);
        check("abort_sdo", int'(sdo), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_no_done", int'(done), 0);
        clk_step(1'b0);
        check("abort_no_done_later", int'(done), 0);
        check("abort_bits_consumed", exp_q.size(), 0);
        repeat (4) clk_step(1'b0);

        // Async reset mid-frame after 11 ticks: header bits 1,0,1,0,0,1 seen
        push_bits(8'hA5, 6);
        begin_frame(4'b0011, 4'b1001);
        repeat (11) tick(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("pre_reset_sclk", int'(sclk), 1);
        check("pre_reset_sdo", int'(sdo), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_frame", int'(frame), 0);
        check("async_rst_sclk", int'(sclk), 0);
        check("async_rst_sdo", int'(sdo), 0);
        check("async_rst_busy", int'(busy), 0);
        check("reset_bits_consumed", exp_q.size(), 0);
        exp_q.delete();
        clk_step(1'b0);
        rst_n = 1'b1;
        clk_step(1'b0);

        // curr=0111 prev=0000 -> 1,0,1,0,1,0,0,0, parity 1
        run_frame(4'b0111, 4'b0000, 8'b1010_1000, 1'b1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
